// File: rtl/regfile8x16_sb.sv
// 8 x 16-bit register file with per-register busy bits (scoreboard) and a sticky error flag.
// Define RF_BYPASS_EN to make a same-cycle writeback visible on the read ports.
module regfile8x16_sb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  read1RegSel,
  input  logic [2:0]  read2RegSel,
  input  logic        read1En,
  input  logic        read2En,
  output logic [15:0] read1Data,
  output logic [15:0] read2Data,
  input  logic        writeEn,
  input  logic [2:0]  writeRegSel,
  input  logic [15:0] writeData,
  input  logic        issueEn,
  input  logic [2:0]  issueRegSel,
  output logic        read1Busy,
  output logic        read2Busy,
  output logic        stall,
  output logic        err
);

  logic [15:0] regs [8];
  logic [7:0]  busy_reg;
  logic [7:0]  busy_next;
  logic [7:0]  issue_dec;
  logic [7:0]  write_dec;
  logic        err_reg;
  logic        err_next;
  logic        same_reg;
  logic        issue_conflict;
  logic        write_conflict;

  // A set from issue wins over a clear from writeback on the same register.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_busy
      assign issue_dec[gi] = issueEn && (issueRegSel == 3'(gi));
      assign write_dec[gi] = writeEn && (writeRegSel == 3'(gi));
      assign busy_next[gi] = issue_dec[gi] | (busy_reg[gi] & ~write_dec[gi]);
    end
  endgenerate

  assign same_reg       = issueEn && writeEn && (issueRegSel == writeRegSel);
  assign issue_conflict = issueEn && busy_reg[issueRegSel] && !same_reg;
  assign write_conflict = writeEn && !busy_reg[writeRegSel] && !same_reg;
  assign err_next       = err_reg | issue_conflict | write_conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 16'h0000;
      end
      busy_reg <= 8'h00;
      err_reg  <= 1'b0;
    end else begin
      if (writeEn) begin
        regs[writeRegSel] <= writeData;
      end
      busy_reg <= busy_next;
      err_reg  <= err_next;
    end
  end

  always_comb begin
    read1Data = regs[read1RegSel];
    read2Data = regs[read2RegSel];
    read1Busy = busy_reg[read1RegSel];
    read2Busy = busy_reg[read2RegSel];
`ifdef RF_BYPASS_EN
    // Gated by rst_n so the ports still read zero while reset is held.
    if (rst_n && writeEn && (writeRegSel == read1RegSel)) begin
      read1Data = writeData;
      read1Busy = 1'b0;
    end
    if (rst_n && writeEn && (writeRegSel == read2RegSel)) begin
      read2Data = writeData;
      read2Busy = 1'b0;
    end
`endif
  end

  assign stall = (read1En & read1Busy) | (read2En & read2Busy);
  assign err   = err_reg;

endmodule

// File: tb/tb_regfile8x16_sb.sv
// Scoreboard bench for regfile8x16_sb: stimulus queues expected port values, a monitor compares.
// Expected values follow the RF_BYPASS_EN setting of the build.
module tb_regfile8x16_sb;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  read1RegSel = '0, read2RegSel = '0;
  logic        read1En = 1'b0, read2En = 1'b0;
  logic [15:0] read1Data, read2Data;
  logic        writeEn = 1'b0;
  logic [2:0]  writeRegSel = '0;
  logic [15:0] writeData = '0;
  logic        issueEn = 1'b0;
  logic [2:0]  issueRegSel = '0;
  logic        read1Busy, read2Busy, stall, err;

  regfile8x16_sb dut (
    .clk(clk), .rst_n(rst_n),
    .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
    .read1En(read1En), .read2En(read2En),
    .read1Data(read1Data), .read2Data(read2Data),
    .writeEn(writeEn), .writeRegSel(writeRegSel), .writeData(writeData),
    .issueEn(issueEn), .issueRegSel(issueRegSel),
    .read1Busy(read1Busy), .read2Busy(read2Busy),
    .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        b1;
    logic        b2;
    logic        st;
    logic        er;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (read1Data !== e.d1 || read2Data !== e.d2 || read1Busy !== e.b1 ||
            read2Busy !== e.b2 || stall !== e.st || err !== e.er) begin
          errors++;
          $display("FAIL %s: got d1=%h d2=%h b1=%b b2=%b stall=%b err=%b, expected d1=%h d2=%h b1=%b b2=%b stall=%b err=%b",
                   e.name, read1Data, read2Data, read1Busy, read2Busy, stall, err,
                   e.d1, e.d2, e.b1, e.b2, e.st, e.er);
        end else begin
          $display("ok   %s: d1=%h d2=%h b1=%b b2=%b stall=%b err=%b",
                   e.name, read1Data, read2Data, read1Busy, read2Busy, stall, err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [15:0] d1, input logic [15:0] d2,
                            input logic b1, input logic b2, input logic st, input logic er);
    exp_t e;
    #2;
    e.name = nm; e.d1 = d1; e.d2 = d2; e.b1 = b1; e.b2 = b2; e.st = st; e.er = er;
    q.push_back(e);
    -> sample_ev;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state, both ports over every register
    for (int i = 0; i < 8; i++) begin
      cyc();
      read1RegSel = 3'(i); read2RegSel = 3'(7 - i);
      read1En = 1'b1; read2En = 1'b1;
      expect_out("rst_sweep", 16'h0000, 16'h0000, 0, 0, 0, 0);
    end
    read1En = 1'b0; read2En = 1'b0;

    // Issue R3, write BEEF, read back
    cyc(); issueEn = 1; issueRegSel = 3; read1RegSel = 3; read2RegSel = 0;
    expect_out("r3_issue", 16'h0000, 16'h0000, 0, 0, 0, 0);
    cyc(); issueEn = 0; writeEn = 1; writeRegSel = 3; writeData = 16'hBEEF;
    expect_out("r3_write", BYP ? 16'hBEEF : 16'h0000, 16'h0000, BYP ? 1'b0 : 1'b1, 0, 0, 0);
    cyc(); writeEn = 0;
    expect_out("r3_read", 16'hBEEF, 16'h0000, 0, 0, 0, 0);

    // R5 hazard and its resolution
    cyc(); issueEn = 1; issueRegSel = 5; read2RegSel = 5;
    cyc(); issueEn = 0; read2En = 1;
    expect_out("r5_busy", 16'hBEEF, 16'h0000, 0, 1, 1, 0);
    cyc(); writeEn = 1; writeRegSel = 5; writeData = 16'h1234;
    expect_out("r5_write", 16'hBEEF, BYP ? 16'h1234 : 16'h0000, 0,
               BYP ? 1'b0 : 1'b1, BYP ? 1'b0 : 1'b1, 0);
    cyc(); writeEn = 0;
    expect_out("r5_after", 16'hBEEF, 16'h1234, 0, 0, 0, 0);
    read2En = 0;

    // Same-cycle issue and writeback on R2: busy stays set, data written
    cyc(); issueEn = 1; issueRegSel = 2; read1RegSel = 2;
    cyc(); writeEn = 1; writeRegSel = 2; writeData = 16'h00AA;
    expect_out("r2_same", BYP ? 16'h00AA : 16'h0000, 16'h1234, BYP ? 1'b0 : 1'b1, 0, 0, 0);
    cyc(); issueEn = 0; writeEn = 0; read1En = 1;
    expect_out("r2_kept", 16'h00AA, 16'h1234, 1, 0, 1, 0);
    cyc(); read1En = 0; writeEn = 1; writeRegSel = 2; writeData = 16'h00AA;
    cyc(); writeEn = 0;
    expect_out("r2_clear", 16'h00AA, 16'h1234, 0, 0, 0, 0);

    // Double issue on R6 sets sticky err
    cyc(); issueEn = 1; issueRegSel = 6; read1RegSel = 6;
    cyc();
    expect_out("r6_dup", 16'h0000, 16'h1234, 1, 0, 0, 0);
    cyc(); issueEn = 0;
    expect_out("r6_err", 16'h0000, 16'h1234, 1, 0, 0, 1);
    cyc(); writeEn = 1; writeRegSel = 6; writeData = 16'h0777;
    cyc(); writeEn = 0;
    expect_out("r6_sticky", 16'h0777, 16'h1234, 0, 0, 0, 1);

    // Fresh run: writeback to a non-busy register sets err, data still lands
    cyc(); rst_n = 0;
    expect_out("rst2", 16'h0000, 16'h0000, 0, 0, 0, 0);
    cyc(); rst_n = 1; read1RegSel = 1; writeEn = 1; writeRegSel = 1; writeData = 16'h5555;
    expect_out("r1_write", BYP ? 16'h5555 : 16'h0000, 16'h0000, 0, 0, 0, 0);
    cyc(); writeEn = 0;
    expect_out("r1_err", 16'h5555, 16'h0000, 0, 0, 0, 1);

    // R4 = FFFF busy, independent issue R7; then reset mid-cycle
    cyc(); rst_n = 0;
    cyc(); rst_n = 1; issueEn = 1; issueRegSel = 4;
    cyc(); issueRegSel = 7; writeEn = 1; writeRegSel = 4; writeData = 16'hFFFF;
    cyc(); issueRegSel = 4; writeEn = 0;
    cyc(); issueEn = 0; read1RegSel = 4; read2RegSel = 7;
    expect_out("r4_set", 16'hFFFF, 16'h0000, 1, 1, 0, 0);
    #2 rst_n = 0;
    expect_out("async_rst", 16'h0000, 16'h0000, 0, 0, 0, 0);

    cyc(); rst_n = 1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile8x16_sb.md
REGFILE8X16_SB -- requirements
Module: regfile8x16_sb

Interface
REQ-001 SHALL provide port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL provide ports read1RegSel and read2RegSel, input, 3 each, read-port register indices.
REQ-004 SHALL provide ports read1En and read2En, input, 1 each, read port in use (qualifies hazard check).
REQ-005 SHALL provide ports read1Data and read2Data, output, 16 each, read-port data.
REQ-006 SHALL provide ports writeEn (input, 1), writeRegSel (input, 3) and writeData (input, 16), writeback port.
REQ-007 SHALL provide ports issueEn (input, 1) and issueRegSel (input, 3), mark destination register pending.
REQ-008 SHALL provide ports read1Busy and read2Busy, output, 1 each, selected register pending.
REQ-009 SHALL provide port stall, output, 1, read-after-write hazard on any enabled read port.
REQ-010 SHALL provide port err, output, 1, sticky protocol-violation flag.

Function
REQ-011 SHALL hold 8 registers of 16 bits (R0-R7) plus 8 busy bits, one per register.
REQ-012 SHALL return readNData = R[readNRegSel] combinationally (zero-cycle read latency).
REQ-013 SHALL write R[writeRegSel] <= writeData on the rising edge when writeEn=1; R0 is an ordinary writable register.
REQ-014 SHALL set busy[issueRegSel] on the rising edge when issueEn=1.
REQ-015 SHALL clear busy[writeRegSel] on the rising edge when writeEn=1.
REQ-016 SHALL leave the bit set when issueEn and writeEn target the same register in one cycle (set wins: new producer outstanding).
REQ-017 SHALL drive readNBusy = busy[readNRegSel], subject to REQ-024.
REQ-018 SHALL drive stall = (read1En & read1Busy) | (read2En & read2Busy), combinational.
REQ-019 SHALL set err on the rising edge when issueEn=1 targets a register whose busy bit is 1 and is not cleared by a writeEn in the same cycle (one outstanding producer per register).
REQ-020 SHALL set err on the rising edge when writeEn=1 targets a register whose busy bit is 0 and issueEn does not target it in the same cycle.
REQ-021 SHALL hold err at 1 until reset once set; err never blocks register or busy updates.
REQ-022 SHALL allow issueEn and writeEn to different registers in one cycle, both taking effect independently.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously clear R0-R7 to 16'h0000, all busy bits and err to 0; outputs read Data=0, Busy=0, stall=0, err=0; an operation in flight at reset assertion is discarded.

Configuration
REQ-024 SHALL support macro RF_BYPASS_EN: when defined, if writeEn=1 and writeRegSel==readNRegSel, readNData = writeData and readNBusy = 0 in that cycle (writes visible the same cycle); when undefined, readNData shows the stored value and readNBusy the stored bit until the following edge.

Verification
REQ-025 SHALL pass: reset, then read both ports R0-R7 -> every readData = 16'h0000, Busy = 0, stall = 0, err = 0.
REQ-026 SHALL pass: write R3 = 16'hBEEF (issue R3 one cycle earlier), next cycle read1RegSel = 3 -> read1Data = 16'hBEEF, err = 0.
REQ-027 SHALL pass: issueEn on R5, next cycle read2En = 1, read2RegSel = 5 -> read2Busy = 1, stall = 1; writeEn R5 = 16'h1234 -> same cycle read2Data = 16'h1234 and stall = 0 with RF_BYPASS_EN, stall = 1 and old data without; following cycle stall = 0, data 16'h1234 in both builds.
REQ-028 SHALL pass: R2 busy, same cycle issueEn R2 and writeEn R2 = 16'h00AA -> busy[2] stays 1, R2 = 16'h00AA, err = 0.
REQ-029 SHALL pass: R6 busy, issueEn R6 alone -> err = 1 next edge and remains 1; writeEn R1 with R1 not busy in a fresh run -> err = 1.
REQ-030 SHALL pass: rst_n driven low mid-cycle with R4 = 16'hFFFF and busy[4] = 1 -> read Data and Busy for R4 go to 0 immediately, without a clock edge.
